// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and limits for the 12-hour clock set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HR   = 2'd1,
    SET_MIN  = 2'd2,
    SET_AMPM = 2'd3
  } mode_t;

  localparam logic [3:0] HOURS_MAX = 4'd12;
  localparam logic [3:0] HOURS_MIN = 4'd1;
  localparam logic [5:0] MIN_MAX   = 6'd59;

  // Hours outside 1..12 coming from the core are treated as 12.
  function automatic logic [3:0] sanitize_hours(input logic [3:0] h);
    return (h >= HOURS_MIN && h <= HOURS_MAX) ? h : HOURS_MAX;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bus between the set controller (master) and the 12-hour timekeeping core (slave).
interface clock_set_ctrl_if;
  logic       tick_en;
  logic       load;
  logic [3:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic       load_am_pm;
  logic [3:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       cur_am_pm;

  modport master (
    output tick_en, load, load_hours, load_minutes, load_seconds, load_am_pm,
    input  cur_hours, cur_minutes, cur_am_pm
  );

  modport slave (
    input  tick_en, load, load_hours, load_minutes, load_seconds, load_am_pm,
    output cur_hours, cur_minutes, cur_am_pm
  );
endinterface

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-count debounce, rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          evt_q, evt_d;

  // Accept a level change only after DEBOUNCE_CYC consecutive differing samples;
  // the press pulse is issued on the same edge the level rises.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    cnt_d   = '0;
    evt_d   = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        evt_d   = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      evt_q   <= evt_d;
    end
  end

  assign press_evt = evt_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// 1 Hz tick generator and button-driven hours/minutes/AM-PM set sequencer.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_mode,
  input  logic                    btn_inc,
  clock_set_ctrl_if.master        core,
  output logic [1:0]              mode,
  output logic                    blink
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PS_HALF = PW'(CLK_HZ / 2);

  logic mode_evt, inc_evt;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_btn (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_mode),
    .press_evt (mode_evt)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_btn (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_inc),
    .press_evt (inc_evt)
  );

  mode_t         state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic          tick_q, tick_d;
  logic          load_q, load_d;
  logic [3:0]    hr_q, hr_d;
  logic [5:0]    min_q, min_d;
  logic          pm_q, pm_d;

  // Next-state: prescaler, mode sequencing (mode press beats inc press), shadow edits.
  always_comb begin
    state_d = state_q;
    ps_d    = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
    tick_d  = (state_q == RUN) && (ps_q == PS_LAST);
    load_d  = 1'b0;
    hr_d    = hr_q;
    min_d   = min_q;
    pm_d    = pm_q;
    if (mode_evt) begin
      unique case (state_q)
        RUN: begin
          state_d = SET_HR;
          hr_d    = sanitize_hours(core.cur_hours);
          min_d   = core.cur_minutes;
          pm_d    = core.cur_am_pm;
        end
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_AMPM;
        SET_AMPM: begin
          state_d = RUN;
          load_d  = 1'b1;
          ps_d    = '0;
        end
      endcase
    end else if (inc_evt) begin
      unique case (state_q)
        SET_HR:   hr_d  = (hr_q == HOURS_MAX) ? HOURS_MIN : hr_q + 4'd1;
        SET_MIN:  min_d = (min_q >= MIN_MAX) ? '0 : min_q + 6'd1;
        SET_AMPM: pm_d  = ~pm_q;
        RUN:      ;
      endcase
    end
  end

  // State registers; reset returns to RUN with a 12:00 AM shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ps_q    <= '0;
      tick_q  <= 1'b0;
      load_q  <= 1'b0;
      hr_q    <= HOURS_MAX;
      min_q   <= '0;
      pm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      tick_q  <= tick_d;
      load_q  <= load_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      pm_q    <= pm_d;
    end
  end

  assign core.tick_en      = tick_q;
  assign core.load         = load_q;
  assign core.load_hours   = hr_q;
  assign core.load_minutes = min_q;
  assign core.load_seconds = '0;
  assign core.load_am_pm   = pm_q;
  assign mode              = state_q;
  assign blink             = (state_q != RUN) && (ps_q >= PS_HALF);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with a cycle-level behavioural model.
module tb_clock_set_ctrl;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int LAT    = 2 + DEB + 1;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] mode;
  logic       blink;

  logic [3:0] cur_h;
  logic [5:0] cur_m;
  logic       cur_p;

  clock_set_ctrl_if core_if ();

  assign core_if.cur_hours   = cur_h;
  assign core_if.cur_minutes = cur_m;
  assign core_if.cur_am_pm   = cur_p;

  clock_set_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .core     (core_if),
    .mode     (mode),
    .blink    (blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state.
  int m_mode, m_hr, m_min, m_pm, phase, mode_at, inc_at, tick_seen;
  bit m_load, m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hr = 12; m_min = 0; m_pm = 0; phase = 0;
    m_load = 0; m_tick = 0; mode_at = -1; inc_at = -1;
  endtask

  // One clock edge: advance the model, then compare every output.
  task automatic step();
    int prev;
    @(posedge clk);
    cyc++;
    prev   = m_mode;
    m_load = 0;
    m_tick = 0;
    if (rst) begin
      model_reset();
    end else begin
      phase++;
      m_tick = (prev == 0) && (phase % CLK_HZ == 0);
      if (cyc == mode_at) begin
        if (m_mode == 0) begin
          m_hr  = (cur_h >= 1 && cur_h <= 12) ? int'(cur_h) : 12;
          m_min = int'(cur_m);
          m_pm  = int'(cur_p);
        end else if (m_mode == 3) begin
          m_load = 1;
          phase  = 0;
        end
        m_mode = (m_mode + 1) % 4;
      end else if (cyc == inc_at) begin
        if (m_mode == 1) m_hr = m_hr % 12 + 1;
        else if (m_mode == 2) m_min = (m_min + 1) % 60;
        else if (m_mode == 3) m_pm = 1 - m_pm;
      end
    end
    #1;
    if (core_if.tick_en === 1'b1) tick_seen++;
    chk("tick_en", 32'(core_if.tick_en), 32'(m_tick));
    chk("load", 32'(core_if.load), 32'(m_load));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("load_hours", 32'(core_if.load_hours), 32'(m_hr));
    chk("load_minutes", 32'(core_if.load_minutes), 32'(m_min));
    chk("load_seconds", 32'(core_if.load_seconds), 32'd0);
    chk("load_am_pm", 32'(core_if.load_am_pm), 32'(m_pm));
    chk("blink", 32'(blink), 32'((m_mode != 0) && ((phase % CLK_HZ) >= CLK_HZ / 2)));
  endtask

  task automatic press(input bit do_mode, input bit do_inc, input int hold);
    if (do_mode) begin btn_mode = 1'b1; mode_at = cyc + LAT; end
    if (do_inc)  begin btn_inc  = 1'b1; inc_at  = cyc + LAT; end
    repeat (hold) step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (DEB + 4) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_h = 4'd0; cur_m = 6'd0; cur_p = 1'b0;
    model_reset();
    tick_seen = 0;
    repeat (3) step();
    rst = 1'b0;

    // 1: free run, ticks at 10, 20, 30
    repeat (35) step();
    chk("tick_count_run", 32'(tick_seen), 32'd3);

    // 2: capture 3:45 PM, stay in SET_HR with ticks suppressed
    cur_h = 4'd3; cur_m = 6'd45; cur_p = 1'b1;
    press(1'b1, 1'b0, LAT + 1);
    tick_seen = 0;
    repeat (25) step();
    chk("tick_count_set", 32'(tick_seen), 32'd0);
    press(1'b1, 1'b0, LAT + 1);
    press(1'b1, 1'b0, LAT + 1);
    press(1'b1, 1'b0, LAT + 1);

    // 3: hour wrap 11->12->1, minute wrap 59->0
    cur_h = 4'd11; cur_m = 6'd59; cur_p = 1'b1;
    press(1'b1, 1'b0, LAT + 1);
    press(1'b0, 1'b1, LAT + 1);
    press(1'b0, 1'b1, LAT + 1);
    press(1'b1, 1'b0, LAT + 1);
    press(1'b0, 1'b1, LAT + 1);
    press(1'b1, 1'b0, LAT + 1);

    // 4: toggle PM->AM and commit 1:00:00 AM; next tick 10 cycles after load
    press(1'b0, 1'b1, LAT + 1);
    press(1'b1, 1'b0, LAT + 1);
    repeat (15) step();

    // 5: glitches ignored, simultaneous press advances mode only, hold does not repeat
    cur_h = 4'd14; cur_m = 6'd7; cur_p = 1'b0;
    press(1'b1, 1'b0, LAT + 1);
    for (int g = 0; g < 5; g++) begin
      btn_inc = 1'b1; repeat (2) step();
      btn_inc = 1'b0; repeat (2) step();
    end
    repeat (DEB + 4) step();
    press(1'b1, 1'b1, LAT + 1);
    press(1'b0, 1'b1, 30);

    // 6: reset from SET_MIN, then ticks resume from zero
    #2 rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    tick_seen = 0;
    repeat (35) step();
    chk("tick_count_after_rst", 32'(tick_seen), 32'd3);

    // Randomised full set sequences
    for (int it = 0; it < 6; it++) begin
      cur_h = 4'($urandom_range(0, 15));
      cur_m = 6'($urandom_range(0, 59));
      cur_p = 1'($urandom_range(0, 1));
      press(1'b1, 1'b0, $urandom_range(LAT + 1, LAT + 5));
      for (int f = 0; f < 3; f++) begin
        int n_inc;
        n_inc = $urandom_range(0, 13);
        for (int k = 0; k < n_inc; k++) press(1'b0, 1'b1, $urandom_range(LAT + 1, LAT + 5));
        press(1'b1, 1'b0, $urandom_range(LAT + 1, LAT + 5));
      end
      repeat ($urandom_range(0, 25)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
